// File: rtl/uart_tx_arb_pkg.sv
// Shared types and default sizing for the UART transmit arbiter.
package uart_tx_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_DATA_WIDTH     = 8;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    // Round-robin successor of idx in a ring of n entries.
    function automatic int rr_next(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_select.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping past the top index.
module rr_select #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Scan offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        int j;
        j   = 0;
        idx = '0;
        gnt = '0;
        any = |req;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) idx = IW'(j);
        end
        if (any) gnt[idx] = 1'b1;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte streams. A winner is picked
// in IDLE, then holds the transmitter for a whole message (until tlast) or
// until it stays silent for TIMEOUT_CYCLES cycles.
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_REQ-1:0]            s_tvalid,
    input  logic [NUM_REQ-1:0]            s_tlast,
    output logic [NUM_REQ-1:0]            s_tready,
    input  logic [NUM_REQ-1:0]            req_enable,
    output logic [DATA_WIDTH-1:0]         m_tdata,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic                          grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          timeout_pulse
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(TIMEOUT_CYCLES);

    arb_state_t    state_q, state_d;
    logic [IDW-1:0] gid_q, gid_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           tpulse_q, tpulse_d;

    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] tdata_arr;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] rr_gnt;
    logic [IDW-1:0]     rr_idx;
    logic               rr_any;

    logic                  sel_tvalid;
    logic                  sel_tlast;
    logic [DATA_WIDTH-1:0] sel_tdata;
    logic                  hs;

    assign tdata_arr = s_tdata;
    // Mask only gates new grants; a holder keeps its lock regardless.
    assign elig = s_tvalid & req_enable;

    rr_select #(
        .N  (NUM_REQ),
        .IW (IDW)
    ) u_rr (
        .req (elig),
        .ptr (ptr_q),
        .gnt (rr_gnt),
        .idx (rr_idx),
        .any (rr_any)
    );

    assign sel_tvalid = s_tvalid[gid_q];
    assign sel_tlast  = s_tlast[gid_q];
    assign sel_tdata  = tdata_arr[gid_q];
    assign hs         = (state_q == LOCK) && sel_tvalid && m_tready;

    assign grant_valid   = (state_q == LOCK);
    assign grant_id      = gid_q;
    assign timeout_pulse = tpulse_q;

    // Next-state, grant bookkeeping and the LOCK-time data path.
    always_comb begin
        state_d  = state_q;
        gid_d    = gid_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        tpulse_d = 1'b0;
        m_tvalid = 1'b0;
        m_tdata  = '0;
        s_tready = '0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rr_any) begin
                    gid_d   = rr_idx;
                    // Pointer moves past the winner now, so a later forced
                    // release already starts the next search after it.
                    ptr_d   = IDW'(rr_next(int'(rr_idx), NUM_REQ));
                    state_d = LOCK;
                end
            end
            LOCK: begin
                m_tvalid        = sel_tvalid;
                m_tdata         = sel_tdata;
                s_tready[gid_q] = m_tready;
                if (hs) begin
                    // A tlast handshake always wins over the timeout.
                    cnt_d = '0;
                    if (sel_tlast) state_d = IDLE;
                end else if (!sel_tvalid) begin
                    // Only silent cycles count; stalled bytes never release.
                    if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                        cnt_d    = '0;
                        tpulse_d = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and grant registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            gid_q    <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            tpulse_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            gid_q    <= gid_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            tpulse_q <= tpulse_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: each scenario drives byte sources and
// compares outputs against hand-derived cycle timelines.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_tdata;
    logic [3:0]  s_tvalid, s_tlast, s_tready, req_enable;
    logic [7:0]  m_tdata;
    logic        m_tvalid, m_tready, grant_valid, timeout_pulse;
    logic [1:0]  grant_id;

    int errors = 0;
    int checks = 0;

    logic [7:0] src_b [4][4];
    int         src_len [4];
    int         src_pos [4];
    bit         src_nolast [4];

    uart_tx_arbiter #(
        .NUM_REQ        (4),
        .DATA_WIDTH     (8),
        .TIMEOUT_CYCLES (1024)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_tdata       (s_tdata),
        .s_tvalid      (s_tvalid),
        .s_tlast       (s_tlast),
        .s_tready      (s_tready),
        .req_enable    (req_enable),
        .m_tdata       (m_tdata),
        .m_tvalid      (m_tvalid),
        .m_tready      (m_tready),
        .grant_valid   (grant_valid),
        .grant_id      (grant_id),
        .timeout_pulse (timeout_pulse)
    );

    always #5 clk = ~clk;

    task automatic clear_src();
        for (int i = 0; i < 4; i++) begin
            src_len[i] = 0; src_pos[i] = 0; src_nolast[i] = 1'b0;
        end
    endtask

    task automatic load_src(input int i, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input int len, input bit nolast);
        src_b[i][0] = b0; src_b[i][1] = b1; src_b[i][2] = b2; src_b[i][3] = 8'h00;
        src_len[i] = len; src_pos[i] = 0; src_nolast[i] = nolast;
    endtask

    task automatic apply_src();
        for (int i = 0; i < 4; i++) begin
            if (src_pos[i] < src_len[i]) begin
                s_tvalid[i]       = 1'b1;
                s_tdata[i*8 +: 8] = src_b[i][src_pos[i]];
                s_tlast[i]        = !src_nolast[i] && (src_pos[i] == src_len[i] - 1);
            end else begin
                s_tvalid[i]       = 1'b0;
                s_tdata[i*8 +: 8] = 8'h00;
                s_tlast[i]        = 1'b0;
            end
        end
    endtask

    // Advance one clock; sources step forward on the bytes that were accepted.
    task automatic next_cycle();
        logic [3:0] hs;
        hs = s_tvalid & s_tready;
        @(negedge clk);
        for (int i = 0; i < 4; i++) if (hs[i]) src_pos[i]++;
        apply_src();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_src();
        apply_src();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; m_tready = 1'b1; req_enable = 4'hF;
        s_tvalid = 4'hF; s_tlast = 4'hF; s_tdata = 32'h44332211;
        @(negedge clk); #1;
        checks++;
        if ({grant_valid, grant_id, m_tvalid, s_tready, timeout_pulse} !== 9'b0) begin
            errors++;
            $display("FAIL reset_outputs got gv=%b gid=%0d mv=%b rdy=%b tp=%b want all zero",
                     grant_valid, grant_id, m_tvalid, s_tready, timeout_pulse);
        end
        @(negedge clk); #1;
        checks++;
        if (grant_valid !== 1'b0 || m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_held got gv=%b mv=%b want 0 0", grant_valid, m_tvalid);
        end
    endtask

    task automatic test_single();
        do_reset();
        m_tready = 1'b1; req_enable = 4'hF;
        load_src(0, 8'h41, 8'h42, 8'h43, 3, 1'b0);
        apply_src(); #1;
        checks++;
        if (m_tvalid !== 1'b0 || s_tready !== 4'b0) begin
            errors++;
            $display("FAIL single_arb_cycle got mv=%b rdy=%b want 0 0000", m_tvalid, s_tready);
        end
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== 8'h41 + 8'(k) || grant_id !== 2'd0 ||
                s_tready !== 4'b0001) begin
                errors++;
                $display("FAIL single_byte%0d got mv=%b d=%h gid=%0d rdy=%b want 1 %h 0 0001",
                         k, m_tvalid, m_tdata, grant_id, s_tready, 8'h41 + 8'(k));
            end
        end
        next_cycle();
        checks++;
        if (grant_valid !== 1'b0 || m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL single_release got gv=%b mv=%b want 0 0", grant_valid, m_tvalid);
        end
    endtask

    task automatic test_round_robin();
        int bad;
        bad = 0;
        do_reset();
        m_tready = 1'b1; req_enable = 4'hF;
        for (int i = 0; i < 4; i++)
            load_src(i, 8'(8'h10 * (i + 1)), 8'(8'h10 * (i + 1) + 1), 8'h00, 2, 1'b0);
        apply_src(); #1;
        // Every third cycle is the arbitration bubble; requester c/3 otherwise.
        for (int c = 0; c < 13; c++) begin
            if (c > 0) next_cycle();
            if (c % 3 == 0 || c == 12) begin
                if (m_tvalid !== 1'b0 || grant_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL rr_bubble c=%0d got mv=%b gv=%b want 0 0", c, m_tvalid, grant_valid);
                end
            end else if (m_tvalid !== 1'b1 || grant_id !== 2'(c / 3) ||
                         m_tdata !== 8'(8'h10 * (c / 3 + 1) + (c % 3) - 1)) begin
                bad++;
                $display("FAIL rr_byte c=%0d got mv=%b gid=%0d d=%h want 1 %0d %h", c, m_tvalid,
                         grant_id, m_tdata, c / 3, 8'(8'h10 * (c / 3 + 1) + (c % 3) - 1));
            end
        end
        checks++;
        if (bad != 0) errors++;
    endtask

    task automatic test_backpressure();
        int pulses;
        pulses = 0;
        do_reset();
        m_tready = 1'b0; req_enable = 4'hF;
        load_src(1, 8'h55, 8'h56, 8'h00, 2, 1'b0);
        apply_src(); #1;
        for (int c = 0; c < 2000; c++) begin
            next_cycle();
            if (timeout_pulse !== 1'b0) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL bp_no_timeout got pulses=%0d want 0", pulses);
        end
        checks++;
        if (grant_valid !== 1'b1 || grant_id !== 2'd1 || m_tvalid !== 1'b1 || s_tready !== 4'b0) begin
            errors++;
            $display("FAIL bp_hold got gv=%b gid=%0d mv=%b rdy=%b want 1 1 1 0000",
                     grant_valid, grant_id, m_tvalid, s_tready);
        end
        m_tready = 1'b1; #1;
        checks++;
        if (m_tdata !== 8'h55 || s_tready !== 4'b0010) begin
            errors++;
            $display("FAIL bp_byte0 got d=%h rdy=%b want 55 0010", m_tdata, s_tready);
        end
        next_cycle();
        checks++;
        if (m_tdata !== 8'h56 || m_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL bp_byte1 got d=%h mv=%b want 56 1", m_tdata, m_tvalid);
        end
        next_cycle();
        checks++;
        if (grant_valid !== 1'b0 || timeout_pulse !== 1'b0) begin
            errors++;
            $display("FAIL bp_done got gv=%b tp=%b want 0 0", grant_valid, timeout_pulse);
        end
    endtask

    task automatic test_timeout();
        int early;
        early = 0;
        do_reset();
        m_tready = 1'b1; req_enable = 4'hF;
        load_src(2, 8'h77, 8'h00, 8'h00, 1, 1'b1);
        load_src(3, 8'h33, 8'h00, 8'h00, 1, 1'b0);
        apply_src(); #1;
        next_cycle();
        checks++;
        if (grant_id !== 2'd2 || m_tdata !== 8'h77 || m_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL to_first got gid=%0d d=%h mv=%b want 2 77 1", grant_id, m_tdata, m_tvalid);
        end
        // Requester 2 goes silent from cycle 2; release lands on cycle 1026.
        for (int c = 2; c <= 1025; c++) begin
            next_cycle();
            if (timeout_pulse !== 1'b0 || grant_valid !== 1'b1) early++;
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL to_early got bad_cycles=%0d want 0", early);
        end
        next_cycle();
        checks++;
        if (timeout_pulse !== 1'b1 || grant_valid !== 1'b0 || m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL to_pulse got tp=%b gv=%b mv=%b want 1 0 0", timeout_pulse, grant_valid, m_tvalid);
        end
        next_cycle();
        checks++;
        if (timeout_pulse !== 1'b0 || grant_id !== 2'd3 || m_tdata !== 8'h33 || m_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL to_next_grant got tp=%b gid=%0d d=%h mv=%b want 0 3 33 1",
                     timeout_pulse, grant_id, m_tdata, m_tvalid);
        end
    endtask

    task automatic test_mask();
        do_reset();
        m_tready = 1'b1; req_enable = 4'b1101;
        load_src(1, 8'h91, 8'h00, 8'h00, 1, 1'b0);
        load_src(2, 8'hA1, 8'hA2, 8'hA3, 3, 1'b0);
        apply_src(); #1;
        next_cycle();
        checks++;
        if (grant_id !== 2'd2 || m_tdata !== 8'hA1) begin
            errors++;
            $display("FAIL mask_grant got gid=%0d d=%h want 2 a1", grant_id, m_tdata);
        end
        req_enable = 4'b1001;
        next_cycle();
        next_cycle();
        checks++;
        if (grant_id !== 2'd2 || m_tdata !== 8'hA3 || m_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL mask_complete got gid=%0d d=%h mv=%b want 2 a3 1", grant_id, m_tdata, m_tvalid);
        end
        next_cycle();
        checks++;
        if (grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL mask_blocked got gv=%b want 0", grant_valid);
        end
        req_enable = 4'hF;
        next_cycle();
        checks++;
        if (grant_id !== 2'd1 || m_tdata !== 8'h91 || m_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL mask_reenable got gid=%0d d=%h mv=%b want 1 91 1", grant_id, m_tdata, m_tvalid);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        m_tready = 1'b1; req_enable = 4'hF;
        load_src(3, 8'hC1, 8'hC2, 8'hC3, 3, 1'b0);
        apply_src(); #1;
        next_cycle();
        next_cycle();
        checks++;
        if (grant_id !== 2'd3 || m_tdata !== 8'hC2) begin
            errors++;
            $display("FAIL rmid_pre got gid=%0d d=%h want 3 c2", grant_id, m_tdata);
        end
        rst = 1'b1; #1;
        checks++;
        if ({grant_valid, grant_id, m_tvalid, s_tready, timeout_pulse} !== 9'b0) begin
            errors++;
            $display("FAIL rmid_reset got gv=%b gid=%0d mv=%b rdy=%b tp=%b want all zero",
                     grant_valid, grant_id, m_tvalid, s_tready, timeout_pulse);
        end
        clear_src();
        load_src(0, 8'h0A, 8'h00, 8'h00, 1, 1'b0);
        load_src(3, 8'h3A, 8'h00, 8'h00, 1, 1'b0);
        apply_src();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; #1;
        next_cycle();
        checks++;
        if (grant_id !== 2'd0 || m_tdata !== 8'h0A || m_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL rmid_first got gid=%0d d=%h mv=%b want 0 0a 1", grant_id, m_tdata, m_tvalid);
        end
        next_cycle();
        next_cycle();
        checks++;
        if (grant_id !== 2'd3 || m_tdata !== 8'h3A || m_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL rmid_second got gid=%0d d=%h mv=%b want 3 3a 1", grant_id, m_tdata, m_tvalid);
        end
    endtask

    initial begin
        rst = 1'b1; m_tready = 1'b0; req_enable = 4'h0;
        s_tdata = '0; s_tvalid = '0; s_tlast = '0;
        clear_src();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_mask();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of byte-stream requesters sharing one UART transmitter, range 2..8.
REQ-002 Parameter DATA_WIDTH, default 8: byte width; equals the UART core data width.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024: idle cycles allowed inside a locked message before forced release, minimum 2.
REQ-004 clk  in  1  single system clock; all logic rising-edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 s_tdata  in  NUM_REQ*DATA_WIDTH  requester bytes; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 s_tvalid  in  NUM_REQ  per-requester byte valid.
REQ-008 s_tlast  in  NUM_REQ  per-requester last byte of message.
REQ-009 s_tready  out  NUM_REQ  per-requester byte accepted.
REQ-010 req_enable  in  NUM_REQ  arbitration mask; 0 excludes a requester from new grants.
REQ-011 m_tdata  out  DATA_WIDTH  byte to UART core TX input.
REQ-012 m_tvalid  out  1  byte valid to UART core.
REQ-013 m_tready  in  1  UART core TX ready.
REQ-014 grant_valid  out  1  a requester currently holds the transmitter.
REQ-015 grant_id  out  clog2(NUM_REQ)  index of the holding requester.
REQ-016 timeout_pulse  out  1  one-cycle pulse on forced release.

Function
REQ-017 FSM states IDLE and LOCK only.
REQ-018 IDLE: when any requester has s_tvalid=1 and req_enable=1, register the winner into grant_id, set grant_valid, go to LOCK next cycle.
REQ-019 Round-robin: search starts at last-granted index +1, wrapping from NUM_REQ-1 to 0; after reset the search starts at 0.
REQ-020 LOCK: m_tdata/m_tvalid combinationally equal the granted requester's tdata/tvalid; s_tready[grant_id]=m_tready; every other s_tready is 0.
REQ-021 IDLE: m_tvalid=0 and all s_tready=0; no byte passes in the arbitration cycle.
REQ-022 Latency: tvalid at cycle N with FSM in IDLE gives m_tvalid at N+1; exactly one bubble cycle between messages.
REQ-023 A handshake (m_tvalid & m_tready) with the granted tlast=1 returns the FSM to IDLE next cycle and clears grant_valid.
REQ-024 Clearing req_enable of the holder mid-message does not abort the message; the mask affects new grants only.
REQ-025 Timeout counter: in LOCK, increments each cycle the granted s_tvalid=0; clears on every handshake and on entering LOCK.
REQ-026 On counter = TIMEOUT_CYCLES-1: go to IDLE, pulse timeout_pulse for 1 cycle, and advance the round-robin pointer past the holder.
REQ-027 Cycles with m_tvalid=1 and m_tready=0 do not count toward timeout; backpressure never causes release.
REQ-028 Simultaneous tlast handshake and timeout threshold: treat as normal completion with no timeout_pulse.
REQ-029 Data is neither buffered nor reordered; bytes of one message reach m_tdata contiguously and in order.

Reset
REQ-030 While rst=1: FSM=IDLE, grant_valid=0, grant_id=0, pointer=0, timeout counter=0, timeout_pulse=0, m_tvalid=0, all s_tready=0.
REQ-031 Reset asserted mid-message abandons the message; after release, arbitration restarts from requester 0.

Structure
REQ-032 Package uart_tx_arb_pkg holds the state enum {IDLE, LOCK} and the default NUM_REQ, DATA_WIDTH and TIMEOUT_CYCLES constants.
REQ-033 Round-robin selection is one sub-module, rr_select: inputs request vector and pointer; outputs one-hot grant, index and any-request; purely combinational.

Verification
REQ-034 Req0 sends 3 bytes 0x41,0x42,0x43 (last on 0x43) with m_tready=1 -> m_tdata 41,42,43 on consecutive cycles starting 1 cycle after tvalid; grant_id=0.
REQ-035 Req0–3 each hold a 2-byte message from reset -> grant order 0,1,2,3 with one bubble cycle between messages.
REQ-036 Req1 locked; m_tready=0 for 2000 cycles -> no timeout_pulse; grant held; bytes complete after m_tready=1.
REQ-037 Req2 sends 1 byte without tlast then drops tvalid -> timeout_pulse exactly 1024 cycles later; next grant goes to req3 if it is pending.
REQ-038 req_enable[1]=0 with req1 and req2 pending -> req2 granted; clearing req_enable[2] mid-message still completes req2's message.
REQ-039 rst pulsed while req3 holds a grant -> all outputs at reset values; afterwards req0 and req3 pending -> req0 granted first.
